// File: rtl/ttt_pkg.sv
// ttt_pkg: shared constants and types for the tic-tac-toe keypad, game-control and
// dot-matrix renderer blocks.
//   - Cell codes stored two bits per cell in the 18-bit board word.
//   - Dot-matrix geometry, board placement offsets and grid column positions.
//   - Frame snapshot record and a cell extraction helper.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;
  localparam logic [1:0] CELL_BAD   = 2'b11;

  localparam int unsigned DOT_ROWS  = 10;
  localparam int unsigned DOT_COLS  = 14;
  localparam int unsigned BOARD_W   = 11;
  localparam int unsigned NUM_CELLS = 9;

  localparam int unsigned OFF_LEFT  = 0;
  localparam int unsigned OFF_RIGHT = 3;

  localparam int unsigned GRID_COL_A = 3;
  localparam int unsigned GRID_COL_B = 7;

  // Row index that carries the turn indicator rather than board pixels.
  localparam logic [3:0] TURN_ROW = 4'd9;

  // Inputs captured once per frame so a frame is always drawn from one consistent state.
  typedef struct packed {
    logic [17:0] board;
    logic        is_right;
    logic        turn_o;
    logic [3:0]  cursor;
  } snap_t;

  // Extract the 2-bit code of cell idx (0..8, row-major from top-left).
  function automatic logic [1:0] cell_code(input logic [17:0] board, input logic [3:0] idx);
    logic [4:0] base;
    base = {idx, 1'b0};
    return board[base +: 2];
  endfunction

endpackage

// File: rtl/ttt_glyph_rom.sv
// ttt_glyph_rom: combinational glyph lookup for one cell.
// Ports:
//   i_cell      - 2-bit cell code (empty, X, O, invalid)
//   i_glyph_row - glyph row 0..2 within the cell
//   o_pixels    - 3 pixels for that row; bit 0 = leftmost column of the cell
module ttt_glyph_rom
  import ttt_pkg::*;
(
  input  logic [1:0] i_cell,
  input  logic [1:0] i_glyph_row,
  output logic [2:0] o_pixels
);

  logic w_mid_row;

  always_comb begin
    w_mid_row = (i_glyph_row == 2'd1);
    o_pixels  = 3'b000;
    unique case (i_cell)
      CELL_EMPTY: o_pixels = 3'b000;
      CELL_X:     o_pixels = w_mid_row ? 3'b010 : 3'b101;
      CELL_O:     o_pixels = w_mid_row ? 3'b101 : 3'b111;
      CELL_BAD:   o_pixels = 3'b111;
      default:    o_pixels = 3'b000;
    endcase
  end

endmodule

// File: rtl/ttt_dot_renderer.sv
// ttt_dot_renderer: raster-scans the tic-tac-toe board onto a 10x14 dot matrix, one row per
// prescaler tick. Draws grid lines, X/O glyphs, a blinking cursor cell and a turn indicator.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-low reset
//   en       - display enable; when low outputs are zero but scanning continues
//   board    - 9 cells x 2 bits, row-major from top-left
//   is_right - board drawn at column offset 3 when set, else offset 0
//   turn_o   - 1 = O to move, 0 = X to move
//   cursor   - 0 = none, 1..9 = cell (cursor-1), 10..15 = none
//   dot_row  - one-hot active-high row select, bit 0 = top row
//   dot_col  - active-high pixels for the selected row, bit 0 = leftmost column
module ttt_dot_renderer
  import ttt_pkg::*;
#(
  parameter int unsigned DIV          = 12500,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [17:0]         board,
  input  logic                is_right,
  input  logic                turn_o,
  input  logic [3:0]          cursor,
  output logic [DOT_ROWS-1:0] dot_row,
  output logic [DOT_COLS-1:0] dot_col
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_row;
  logic [FR_W-1:0]     r_frame_cnt;
  logic                r_phase;
  snap_t               r_snap;
  logic [DOT_ROWS-1:0] r_dot_row;
  logic [DOT_COLS-1:0] r_dot_col;

  logic                w_tick;
  logic                w_frame_start;
  logic                w_blink_wrap;
  logic                w_phase;
  snap_t               w_snap;
  logic [1:0]          w_cell_row;
  logic [1:0]          w_glyph_row;
  logic                w_cur_valid;
  logic [3:0]          w_cur_idx;
  logic [3:0]          w_idx     [3];
  logic [1:0]          w_code    [3];
  logic [2:0]          w_rom_px  [3];
  logic [2:0]          w_cell_px [3];
  logic [BOARD_W-1:0]  w_local;
  logic [DOT_COLS-1:0] w_pixels;

  // Frame-start decisions: the snapshot and blink phase used for row 0 are the values
  // being latched on that same tick, so the whole frame is drawn from one state.
  always_comb begin
    w_tick        = (r_cnt == CNT_W'(DIV - 1));
    w_frame_start = w_tick && (r_row == 4'd0);
    w_blink_wrap  = (r_frame_cnt == FR_W'(BLINK_FRAMES - 1));
    w_phase       = (w_frame_start && w_blink_wrap) ? ~r_phase : r_phase;
    if (w_frame_start) begin
      w_snap = '{board: board, is_right: is_right, turn_o: turn_o, cursor: cursor};
    end else begin
      w_snap = r_snap;
    end
  end

  // Cell selection for the current board row; row 9 parks on cell row 0 (unused there).
  always_comb begin
    if (r_row < TURN_ROW) begin
      w_cell_row  = 2'(r_row / 4'd3);
      w_glyph_row = 2'(r_row % 4'd3);
    end else begin
      w_cell_row  = 2'd0;
      w_glyph_row = 2'd0;
    end
    for (int j = 0; j < 3; j++) begin
      w_idx[j]  = 4'(int'(w_cell_row) * 3 + j);
      w_code[j] = cell_code(w_snap.board, w_idx[j]);
    end
  end

  for (genvar j = 0; j < 3; j++) begin : g_rom
    ttt_glyph_rom u_glyph_rom (
      .i_cell      (w_code[j]),
      .i_glyph_row (w_glyph_row),
      .o_pixels    (w_rom_px[j])
    );
  end

  // Cursor overlay: hidden phase blanks the cell; shown phase marks an empty cell with a
  // centre dot so the cursor is visible even where nothing is drawn.
  always_comb begin
    w_cur_valid = (w_snap.cursor != 4'd0) && (w_snap.cursor <= 4'(NUM_CELLS));
    w_cur_idx   = w_snap.cursor - 4'd1;
    for (int j = 0; j < 3; j++) begin
      w_cell_px[j] = w_rom_px[j];
      if (w_cur_valid && (w_cur_idx == w_idx[j])) begin
        if (!w_phase) begin
          w_cell_px[j] = 3'b000;
        end else if (w_code[j] == CELL_EMPTY) begin
          w_cell_px[j] = (w_glyph_row == 2'd1) ? 3'b010 : 3'b000;
        end
      end
    end
  end

  // Column assembly in board-local coordinates, then placement at the chosen offset.
  always_comb begin
    w_local = '0;
    if (r_row < TURN_ROW) begin
      w_local[2:0]       = w_cell_px[0];
      w_local[GRID_COL_A] = 1'b1;
      w_local[6:4]       = w_cell_px[1];
      w_local[GRID_COL_B] = 1'b1;
      w_local[10:8]      = w_cell_px[2];
    end else if (w_snap.turn_o) begin
      w_local[10:8] = 3'b111;
    end else begin
      w_local[2:0] = 3'b111;
    end
    if (w_snap.is_right) begin
      w_pixels = DOT_COLS'(w_local) << OFF_RIGHT;
    end else begin
      w_pixels = DOT_COLS'(w_local) << OFF_LEFT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_row       <= '0;
      r_frame_cnt <= '0;
      r_phase     <= 1'b1;
      r_snap      <= '0;
      r_dot_row   <= '0;
      r_dot_col   <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      if (w_tick) begin
        r_dot_row <= en ? (DOT_ROWS'(1) << r_row) : '0;
        r_dot_col <= en ? w_pixels : '0;
        r_row     <= (r_row == TURN_ROW) ? 4'd0 : r_row + 4'd1;
        if (w_frame_start) begin
          r_snap      <= w_snap;
          r_phase     <= w_phase;
          r_frame_cnt <= w_blink_wrap ? '0 : r_frame_cnt + FR_W'(1);
        end
      end
    end
  end

  assign dot_row = r_dot_row;
  assign dot_col = r_dot_col;

endmodule

// File: tb/tb_ttt_dot_renderer.sv
// Directed bench for ttt_dot_renderer with DIV=4, BLINK_FRAMES=2.
module tb_ttt_dot_renderer;

  localparam int unsigned DIV = 4;
  localparam int unsigned BF  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [17:0] board = '0;
  logic        is_right = 1'b0;
  logic        turn_o = 1'b0;
  logic [3:0]  cursor = '0;
  logic [9:0]  dot_row;
  logic [13:0] dot_col;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ttt_dot_renderer #(
    .DIV          (DIV),
    .BLINK_FRAMES (BF)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .board    (board),
    .is_right (is_right),
    .turn_o   (turn_o),
    .cursor   (cursor),
    .dot_row  (dot_row),
    .dot_col  (dot_col)
  );

  task automatic rst_low();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_release();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step_row();
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] exp_row;
    rst_low();
    n_total++;
    if (dot_row !== 10'h000 || dot_col !== 14'h0000) begin
      $display("FAIL reset_out: row=%h col=%h want 000/0000", dot_row, dot_col);
    end else n_pass++;
    en = 1'b1; board = '0; cursor = '0; turn_o = 1'b0; is_right = 1'b0;
    rst_release();
    repeat (DIV - 1) @(posedge clk);
    #1;
    n_total++;
    if (dot_row !== 10'h000 || dot_col !== 14'h0000) begin
      $display("FAIL pre_tick: row=%h col=%h want 000/0000", dot_row, dot_col);
    end else n_pass++;
    @(posedge clk);
    #1;
    for (int r = 0; r < 10; r++) begin
      if (r > 0) step_row();
      exp_row = 10'd1 << r;
      n_total++;
      if (dot_row !== exp_row || dot_col !== ((r == 9) ? 14'h0007 : 14'h0088)) begin
        $display("FAIL empty_row%0d: row=%h col=%h want %h/%h", r, dot_row, dot_col, exp_row,
                 (r == 9) ? 14'h0007 : 14'h0088);
      end else n_pass++;
    end
  endtask

  task automatic test_glyphs();
    logic [13:0] exp_col [10] = '{14'h08D, 14'h08A, 14'h08D, 14'h0F8, 14'h0D8,
                                  14'h0F8, 14'h088, 14'h088, 14'h088, 14'h007};
    rst_low();
    board = 18'h00201; is_right = 1'b0; turn_o = 1'b0; cursor = '0; en = 1'b1;
    rst_release();
    for (int r = 0; r < 10; r++) begin
      step_row();
      n_total++;
      if (dot_row !== (10'd1 << r) || dot_col !== exp_col[r]) begin
        $display("FAIL glyph_row%0d: row=%h col=%h want %h/%h", r, dot_row, dot_col,
                 10'd1 << r, exp_col[r]);
      end else n_pass++;
    end
  endtask

  task automatic test_right();
    logic [13:0] exp_col [20] = '{14'h468, 14'h450, 14'h468, 14'h7C0, 14'h6C0,
                                  14'h7C0, 14'h440, 14'h440, 14'h440, 14'h038,
                                  14'h08D, 14'h08A, 14'h08D, 14'h0F8, 14'h0D8,
                                  14'h0F8, 14'h088, 14'h088, 14'h088, 14'h700};
    rst_low();
    board = 18'h00201; is_right = 1'b1; turn_o = 1'b0; cursor = '0; en = 1'b1;
    rst_release();
    for (int i = 0; i < 20; i++) begin
      step_row();
      n_total++;
      if (dot_row !== (10'd1 << (i % 10)) || dot_col !== exp_col[i]) begin
        $display("FAIL right_step%0d: row=%h col=%h want %h/%h", i, dot_row, dot_col,
                 10'd1 << (i % 10), exp_col[i]);
      end else n_pass++;
      // Mid-frame change: must not show until the next frame.
      if (i == 2) begin
        is_right = 1'b0;
        turn_o   = 1'b1;
      end
    end
  endtask

  task automatic test_blink();
    logic [7:0]  vis = 8'b1001_1001;
    logic [13:0] exp_col;
    rst_low();
    board = '0; is_right = 1'b0; turn_o = 1'b0; cursor = 4'd5; en = 1'b1;
    rst_release();
    for (int f = 0; f < 8; f++) begin
      for (int r = 0; r < 10; r++) begin
        step_row();
        if (f < 6 && r == 4) begin
          exp_col = vis[f] ? 14'h0A8 : 14'h088;
          n_total++;
          if (dot_row !== 10'h010 || dot_col !== exp_col) begin
            $display("FAIL blink_empty_f%0d: row=%h col=%h want 010/%h", f, dot_row, dot_col,
                     exp_col);
          end else n_pass++;
          if (f == 5) board = 18'h00100;
        end
        if (f >= 6 && r == 3) begin
          exp_col = vis[f] ? 14'h0D8 : 14'h088;
          n_total++;
          if (dot_row !== 10'h008 || dot_col !== exp_col) begin
            $display("FAIL blink_x_f%0d: row=%h col=%h want 008/%h", f, dot_row, dot_col,
                     exp_col);
          end else n_pass++;
        end
      end
    end
  endtask

  task automatic test_enable();
    rst_low();
    board = '0; is_right = 1'b0; turn_o = 1'b0; cursor = '0; en = 1'b1;
    rst_release();
    for (int r = 0; r < 3; r++) step_row();
    n_total++;
    if (dot_row !== 10'h004 || dot_col !== 14'h088) begin
      $display("FAIL en_before: row=%h col=%h want 004/0088", dot_row, dot_col);
    end else n_pass++;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step_row();
      n_total++;
      if (dot_row !== 10'h000 || dot_col !== 14'h0000) begin
        $display("FAIL en_off%0d: row=%h col=%h want 000/0000", i, dot_row, dot_col);
      end else n_pass++;
    end
    en = 1'b1;
    step_row();
    n_total++;
    if (dot_row !== 10'h008 || dot_col !== 14'h088) begin
      $display("FAIL en_resume: row=%h col=%h want 008/0088", dot_row, dot_col);
    end else n_pass++;
  endtask

  task automatic test_mid_reset();
    rst_low();
    board = 18'h00201; is_right = 1'b0; turn_o = 1'b0; cursor = '0; en = 1'b1;
    rst_release();
    for (int r = 0; r < 6; r++) step_row();
    n_total++;
    if (dot_row !== 10'h020 || dot_col !== 14'h0F8) begin
      $display("FAIL mid_row5: row=%h col=%h want 020/00f8", dot_row, dot_col);
    end else n_pass++;
    board = 18'h30000;
    rst_low();
    n_total++;
    if (dot_row !== 10'h000 || dot_col !== 14'h0000) begin
      $display("FAIL mid_rst_out: row=%h col=%h want 000/0000", dot_row, dot_col);
    end else n_pass++;
    rst_release();
    for (int r = 0; r < 9; r++) begin
      step_row();
      if (r == 0 || r >= 6) begin
        n_total++;
        if (dot_row !== (10'd1 << r) || dot_col !== ((r == 0) ? 14'h088 : 14'h788)) begin
          $display("FAIL mid_after_row%0d: row=%h col=%h want %h/%h", r, dot_row, dot_col,
                   10'd1 << r, (r == 0) ? 14'h088 : 14'h788);
        end else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_glyphs();
    test_right();
    test_blink();
    test_enable();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
